// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency MULT/MULTU/DIV/DIVU
// plus single-edge MTHI/MTLO. Busy tells the hazard unit to stall HI/LO users.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [31:0]   opa;
  logic [31:0]   opb;
  logic [2:0]    op;
  logic [CW-1:0] count;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b_u;
  logic [31:0] div_b_s;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;

  // Results come only from the latched operands, so A/B may move during Busy.
  // Divisors are forced nonzero here; the zero case skips the write-back anyway.
  always_comb begin
    prod_s  = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
    prod_u  = {32'd0, opa} * {32'd0, opb};
    abs_a   = opa[31] ? -opa : opa;
    abs_b   = opb[31] ? -opb : opb;
    div_b_u = (opb == 32'd0) ? 32'd1 : opb;
    div_b_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq      = opa / div_b_u;
    ur      = opa % div_b_u;
    sq_mag  = abs_a / div_b_s;
    sr_mag  = abs_a % div_b_s;
    sq      = (opa[31] ^ opb[31]) ? -sq_mag : sq_mag;
    sr      = opa[31] ? -sr_mag : sr_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      opa   <= 32'd0;
      opb   <= 32'd0;
      op    <= OP_NONE;
      count <= '0;
    end else if (Busy) begin
      // Any Start seen here is dropped; the in-flight op owns HI/LO.
      count <= count - 1'b1;
      if (count == CW'(1)) begin
        Busy <= 1'b0;
        case (op)
          OP_MULT:  {HI, LO} <= prod_s;
          OP_MULTU: {HI, LO} <= prod_u;
          OP_DIV: begin
            if (opb != 32'd0) begin
              HI <= sr;
              LO <= sq;
            end
          end
          OP_DIVU: begin
            if (opb != 32'd0) begin
              HI <= ur;
              LO <= uq;
            end
          end
          default: ;
        endcase
      end
    end else if (Start) begin
      case (MDOp)
        OP_MULT, OP_MULTU: begin
          opa   <= A;
          opb   <= B;
          op    <= MDOp;
          count <= CW'(MULT_CYCLES);
          Busy  <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          opa   <= A;
          opb   <= B;
          op    <= MDOp;
          count <= CW'(DIV_CYCLES);
          Busy  <= 1'b1;
        end
        OP_MTHI: HI <= A;
        OP_MTLO: LO <= A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed cases plus random ops against a
// plain-arithmetic HI/LO model; a monitor checks each Busy completion.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic [2:0]  MDOp;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mhi;
  logic [31:0] mlo;
  int          checks = 0;
  int          errors = 0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Start(Start), .MDOp(MDOp),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: 64-bit products, truncating longint division.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint          sa, sb2, p, q, r;
    longint unsigned ua, ub, up;
    logic [63:0]     res;
    res = {hi, lo};
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      OP_MULT:  begin p = sa * sb2; res = p; end
      OP_MULTU: begin up = ua * ub; res = up; end
      OP_DIV: if (b != 0) begin
        q = sa / sb2;
        r = sa % sb2;
        res = {r[31:0], q[31:0]};
      end
      OP_DIVU: if (b != 0) begin
        up  = ua / ub;
        res = {32'd0, up[31:0]};
        up  = ua % ub;
        res[63:32] = up[31:0];
      end
      default: ;
    endcase
    return res;
  endfunction

  // Caller is 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDOp  = OP_NONE;
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (Busy === 1'b0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: actual=busy required=idle within 200 cycles");
    end
  endtask

  task automatic runMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble);
    logic [63:0] r;
    exp_t        e;
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    oldHi    = mhi;
    oldLo    = mlo;
    r        = refResult(op, a, b, mhi, mlo);
    e.hi     = r[63:32];
    e.lo     = r[31:0];
    e.cycles = (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
    sb.push_back(e);
    mhi = e.hi;
    mlo = e.lo;
    applyStimulus(op, a, b);
    if (scramble) begin
      A = 32'd0;
      B = 32'd0;
    end
    checkOutput("busy_set", {31'd0, Busy}, 32'd1);
    checkOutput("busy_hold_hi", HI, oldHi);
    checkOutput("busy_hold_lo", LO, oldLo);
    waitIdle();
  endtask

  task automatic runMt(input logic [2:0] op, input logic [31:0] a);
    if (op == OP_MTHI) mhi = a;
    else mlo = a;
    applyStimulus(op, a, $urandom);
    checkOutput("mt_busy", {31'd0, Busy}, 32'd0);
    checkOutput("mt_hi", HI, mhi);
    checkOutput("mt_lo", LO, mlo);
  endtask

  task automatic runNone(input logic [2:0] op);
    applyStimulus(op, $urandom, $urandom);
    checkOutput("none_busy", {31'd0, Busy}, 32'd0);
    checkOutput("none_hi", HI, mhi);
    checkOutput("none_lo", LO, mlo);
  endtask

  // Monitor: every Busy fall pops one expectation and checks HI/LO and duration.
  initial begin
    bit   prevBusy = 0;
    int   busyCycles = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) begin
        busyCycles++;
      end else if (prevBusy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_empty: actual=completion required=none at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput("done_hi", HI, e.hi);
          checkOutput("done_lo", LO, e.lo);
          checkOutput("done_cycles", busyCycles, e.cycles);
        end
        busyCycles = 0;
      end
      prevBusy = (Busy === 1'b1);
    end
  end

  initial begin
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    reset = 1'b0;
    Start = 1'b0;
    MDOp  = OP_NONE;
    A     = 32'd0;
    B     = 32'd0;
    mhi   = 32'd0;
    mlo   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    runMd(OP_MULT,  32'hFFFFFFFF, 32'h00000002, 0);
    runMd(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1);
    runMd(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1);
    runMd(OP_DIVU,  32'h00000007, 32'h00000002, 0);
    runMd(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
    runMt(OP_MTHI,  32'h11111111);
    runMt(OP_MTLO,  32'h22222222);
    runMd(OP_DIVU,  32'h12345678, 32'h00000000, 0);
    runMd(OP_DIV,   32'h87654321, 32'h00000000, 0);

    // Requests while busy must be dropped without disturbing the MULT.
    e.hi = 32'd0; e.lo = 32'd12; e.cycles = MULT_N;
    sb.push_back(e);
    mhi = 32'd0; mlo = 32'd12;
    applyStimulus(OP_MULT, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    applyStimulus(OP_MTLO, 32'hDEADBEEF, 32'd0);
    applyStimulus(OP_DIV, 32'd100, 32'd3);
    waitIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ignored_busy", {31'd0, Busy}, 32'd0);
    checkOutput("ignored_lo", LO, 32'd12);

    // Reset during a divide: the result is discarded after 4 busy cycles.
    runMt(OP_MTHI, 32'hCAFEF00D);
    e.hi = 32'd0; e.lo = 32'd0; e.cycles = DIV_N;
    sb.push_back(e);
    applyStimulus(OP_DIV, 32'd1000, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    sb.delete();
    e.hi = 32'd0; e.lo = 32'd0; e.cycles = 4;
    sb.push_back(e);
    mhi = 32'd0;
    mlo = 32'd0;
    @(posedge clk);
    #1;
    checkOutput("midreset_busy", {31'd0, Busy}, 32'd0);
    checkOutput("midreset_hi", HI, 32'd0);
    checkOutput("midreset_lo", LO, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset_busy", {31'd0, Busy}, 32'd0);
      checkOutput("post_reset_hilo", HI | LO, 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: runMd(op, a, b, $urandom_range(0, 1) == 1);
        OP_MTHI, OP_MTLO: runMt(op, a);
        default: runNone(op);
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Operands are the rs/rt values read from the register file and carried through the ID/EX pipeline register.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over a fixed multi-cycle latency and holds the architectural HI/LO registers.
- Exposes Busy to the hazard unit, which stalls later HI/LO users (MFHI/MFLO/MT*/MD ops).

Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO update (must be >=1)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO update (must be >=1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low; 0 = reset on the next rising edge
- A  input  32  operand rs (dividend / multiplicand / MTHI/MTLO source)
- B  input  32  operand rt (divisor / multiplier)
- Start  input  1  request strobe, qualified by MDOp
- MDOp  input  3  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=reserved (treated as NONE)
- Busy  output  1  registered; high while an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset:
  - When reset==0 at a rising edge: HI=0, LO=0, Busy=0, counter=0, and the latched operands/op are cleared.
  - This overrides every other input, including mid-operation; the in-flight result is discarded.
- Idle state (Busy==0) with Start==1 at an edge:
  - MULT/MULTU/DIV/DIVU: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 after that edge.
  - MTHI: HI<=A at that edge. MTLO: LO<=A at that edge. Busy stays 0.
  - NONE/reserved: no effect.
- Busy state:
  - Each edge decrements the counter.
  - On the edge where the counter goes 1->0, write the result to HI/LO and set Busy=0.
  - Busy is therefore high for exactly N cycles. New HI/LO values are visible immediately after the N-th edge following the start edge.
  - HI/LO keep their old values throughout Busy.
- Start while Busy:
  - Ignored entirely, including MTHI/MTLO; no re-latch, no counter change.
  - Hazard logic must stall; this case must never corrupt the in-flight operation.
- Start at the same edge Busy falls:
  - Busy is still 1 at that edge, so the request is ignored.
- Arithmetic, computed from the latched operands only; A/B may change freely after acceptance:
  - MULT: {HI,LO} = signed(A) * signed(B), full 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient in LO, remainder in HI.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU with B==0): full DIV_CYCLES busy period runs, then HI and LO are left unchanged.
- Implementation choice: behavioural `*`, `/`, `%` on latched operands, or an iterative datapath. Either is acceptable provided latency and results match exactly.

Test Plan:
- Reset, then MULT with A=0xFFFFFFFF, B=0x00000002 -> Busy=1 for exactly 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFFE; Busy=0.
- MULTU with the same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Changing A/B to 0 during Busy does not alter the result.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x11111111 via MTHI and LO=0x22222222 via MTLO (each takes effect next edge, Busy stays 0). Then DIVU with B=0 -> Busy for 10 cycles; HI/LO remain 0x11111111/0x22222222.
- Start MULT, then issue MTLO A=0xDEADBEEF and DIV during cycles 2-5 of Busy -> both ignored; the MULT result is written on schedule; LO != 0xDEADBEEF.
- Start DIV, drive reset=0 at cycle 4 -> at the next edge Busy=0, HI=LO=0. After release, with no Start, HI/LO stay 0 and Busy stays 0 for 20 cycles.
